// File: rtl/pipe_adder.sv
// pipe_adder: segmented pipelined adder/subtractor, one SEG-bit segment per stage,
// valid/ready handshake with global stall and NZCV-style flags on the output register.
module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NSEG = WIDTH / SEG;
  logic [NSEG-1:0]  v;
  logic [NSEG-1:0]  c_r;
  logic [NSEG-1:0]  cn;
  logic [WIDTH-1:0] a_r [NSEG];
  logic [WIDTH-1:0] b_r [NSEG];
  logic [WIDTH-1:0] s_r [NSEG];
  logic [WIDTH-1:0] sn  [NSEG];
  logic             cy;
  logic             cm;
  logic             adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  // Stage k resolves bits [k*SEG +: SEG]; cm keeps the carry into the MSB for overflow.
  always_comb begin
    cy = 1'b0;
    cm = 1'b0;
    cn = '0;
    for (int k = 0; k < NSEG; k++) begin
      sn[k] = s_r[k];
      cy = c_r[k];
      for (int i = k * SEG; i < (k + 1) * SEG; i++) begin
        if (i == WIDTH - 1) cm = cy;
        sn[k][i] = (a_r[k][i] ^ b_r[k][i]) ^ cy;
        cy = (a_r[k][i] & b_r[k][i]) | ((a_r[k][i] ^ b_r[k][i]) & cy);
      end
      cn[k] = cy;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      c_r <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
      neg <= 1'b0;
    end else if (adv) begin
      v[0] <= in_valid;
      a_r[0] <= a;
      b_r[0] <= sub ? ~b : b;
      c_r[0] <= sub | cin;
      s_r[0] <= '0;
      for (int k = 1; k < NSEG; k++) begin
        v[k] <= v[k-1];
        a_r[k] <= a_r[k-1];
        b_r[k] <= b_r[k-1];
        c_r[k] <= cn[k-1];
        s_r[k] <= sn[k-1];
      end
      out_valid <= v[NSEG-1];
      sum <= sn[NSEG-1];
      cout <= cn[NSEG-1];
      ovf <= cm ^ cn[NSEG-1];
      zero <= sn[NSEG-1] == '0;
      neg <= sn[NSEG-1][WIDTH-1];
    end
  end
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (WIDTH=32, SEG=8, latency 4).
module tb_pipe_adder;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf, zero, neg;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];

  pipe_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    exp_t r;
    logic [31:0] yy;
    logic [32:0] f;
    yy = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + {32'd0, s ? 1'b1 : ci};
    r.sum = f[31:0];
    r.cout = f[32];
    r.ovf = (x[31] == yy[31]) && (f[31] != x[31]);
    r.zero = f[31:0] == 32'd0;
    r.neg = f[31];
    return r;
  endfunction

  // Scoreboard: every result handed to the consumer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL result_extra: got sum=%h with nothing expected", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({sum, cout, ovf, zero, neg} !== e) begin
          errors++;
          $display("FAIL result: got sum=%h c=%b v=%b z=%b n=%b want sum=%h c=%b v=%b z=%b n=%b",
                   sum, cout, ovf, zero, neg, e.sum, e.cout, e.ovf, e.zero, e.neg);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s, input exp_t e);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
    end else q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
    drive(x, y, ci, s, model(x, y, ci, s));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results missing want 0", q.size());
    end
  endtask

  task automatic test_reset();
    int n = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf, zero, neg} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, sum, cout, ovf, zero, neg});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0);
    push(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: out_valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf, zero, neg} !== 37'd0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", {out_valid, sum, cout, ovf, zero, neg});
    end
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, '{32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});
    drive(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    drain();
  endtask

  task automatic test_back_to_back();
    fork
      for (int i = 0; i < 24; i++)
        push($urandom, (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom), 1'($urandom));
      for (int j = 0; j < 30; j++) begin
        out_ready = 1'($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_backpressure();
    fork
      for (int i = 0; i < 6; i++) push(32'h0100_0000 * (i + 1), 32'h00FF_FFFF + i, 1'b0, i[0]);
      begin
        logic [36:0] held;
        int n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        held = {sum, cout, ovf, zero, neg};
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checks++;
          if ({sum, cout, ovf, zero, neg} !== held || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got %h v=%b want %h v=1", {sum, cout, ovf, zero, neg}, out_valid, held);
          end
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    push(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    push(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
    push(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_result: out_valid=%b sum=%h want out_valid 0", out_valid, sum);
      end
    end
    @(posedge clk);
    #1;
    drive(32'd1, 32'd2, 1'b0, 1'b0, '{32'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    do begin
      n++;
      @(posedge clk);
      #1;
    end while (!out_valid && n < 10);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL latency: got %0d cycles want 4", n);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
